// File: rtl/i2c_init_if.sv
// i2c_init_if
// Open-drain I2C pad controls for the codec configuration master.
// Both signals are "release" flags: 1 = pad high-Z (pulled up), 0 = drive low.
//   scl      SCL release
//   sda_out  SDA release (there is no SDA input; ACKs are never read)
// Modports: master drives both lines, slave observes them.
interface i2c_init_if;
  logic scl;
  logic sda_out;

  modport master (output scl, output sda_out);
  modport slave  (input  scl, input  sda_out);
endinterface

// File: rtl/i2c_init.sv
// i2c_init
// Power-on I2C configuration master for the AK4619 codec. After reset it
// waits STARTUP_CYCLES clocks, writes two fixed transactions (registers
// 0x01-0x06, then register 0x00 last so the codec leaves reset already
// configured), and then idles with both lines released until the next reset.
// Every bus phase lasts exactly one clk cycle; a bit slot is 4 phases.
// Ports:
//   clk    block clock (codec LRCK), rising edge
//   rst_n  asynchronous active-low reset; releases both lines at once
//   bus    i2c_init_if.master: registered scl / sda_out release flags
module i2c_init #(
  parameter int         STARTUP_CYCLES = 64,
  parameter logic [6:0] DEV_ADDR       = 7'h10
) (
  input  logic         clk,
  input  logic         rst_n,
  i2c_init_if.master   bus
);

  localparam int CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(STARTUP_CYCLES - 1);

  // Byte ROM indices: 0..7 are the first transaction, 8..10 the second.
  localparam logic [3:0] T1_LAST   = 4'd7;
  localparam logic [3:0] T2_LAST   = 4'd10;
  localparam logic [3:0] ROM_END   = 4'd11;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       phase;
  logic [3:0]       bit_cnt;
  logic [3:0]       byte_idx;
  logic             scl_q;
  logic             sda_q;

  logic [7:0]       cur_byte;
  logic [2:0]       bit_sel;
  logic             cur_bit;

  assign bus.scl     = scl_q;
  assign bus.sda_out = sda_q;

  // Register write sequence, address byte first; the codec auto-increments
  // the register pointer after each data byte.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      4'd0:    cur_byte = {DEV_ADDR, 1'b0};
      4'd1:    cur_byte = 8'h01;
      4'd2:    cur_byte = 8'h0C;
      4'd3:    cur_byte = 8'h1C;
      4'd4:    cur_byte = 8'h00;
      4'd5:    cur_byte = 8'h22;
      4'd6:    cur_byte = 8'h22;
      4'd7:    cur_byte = 8'h00;
      4'd8:    cur_byte = {DEV_ADDR, 1'b0};
      4'd9:    cur_byte = 8'h00;
      4'd10:   cur_byte = 8'h37;
      default: cur_byte = 8'h00;
    endcase
  end

  // MSB first; the 9th slot (bit_cnt == 8) is the ACK slot, where SDA is
  // released and whatever the codec answers is ignored.
  always_comb begin
    bit_sel = 3'(4'd7 - bit_cnt);
    cur_bit = (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_sel];
  end

  // Sequencer. The state names the bus phase being emitted on this edge, so
  // the outputs are registered directly from the current state and phase.
  // SDA only moves while SCL is low, except the deliberate START (1->0) and
  // STOP (0->1) edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_WAIT;
      wait_cnt <= '0;
      phase    <= 2'd0;
      bit_cnt  <= 4'd0;
      byte_idx <= 4'd0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      case (state)
        ST_WAIT: begin
          scl_q <= 1'b1;
          sda_q <= 1'b1;
          if (wait_cnt == LAST_WAIT) begin
            state <= ST_START;
            phase <= 2'd0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // (1,1) (1,0) (1,0) (0,0)
        ST_START: begin
          scl_q <= (phase != 2'd3);
          sda_q <= (phase == 2'd0);
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            state   <= ST_BYTE;
            bit_cnt <= 4'd0;
          end
        end

        // SCL high only in the two middle phases of each bit slot.
        ST_BYTE: begin
          scl_q <= (phase == 2'd1) || (phase == 2'd2);
          sda_q <= cur_bit;
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt  <= 4'd0;
              byte_idx <= byte_idx + 4'd1;
              if ((byte_idx == T1_LAST) || (byte_idx == T2_LAST)) begin
                state <= ST_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        // (0,0) (1,0) (1,0) (1,1); byte_idx already points past the last
        // byte sent, so reaching ROM_END means the whole sequence is out.
        ST_STOP: begin
          scl_q <= (phase != 2'd0);
          sda_q <= (phase == 2'd3);
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            state <= (byte_idx == ROM_END) ? ST_DONE : ST_GAP;
          end
        end

        // Bus-free time between transactions.
        ST_GAP: begin
          scl_q <= 1'b1;
          sda_q <= 1'b1;
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            state <= ST_START;
          end
        end

        ST_DONE: begin
          scl_q <= 1'b1;
          sda_q <= 1'b1;
        end

        default: begin
          state <= ST_DONE;
          scl_q <= 1'b1;
          sda_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init.sv
// tb_i2c_init
// Self-checking bench for i2c_init. A waveform model built from the bus
// rules (idle, START, 9-slot bytes, STOP, gap) is compared against the pads
// every cycle, and an independent bus decoder recovers the bytes written.
// Resets are applied at random points (including mid-byte) and at cycle 200.
module tb_i2c_init;

  logic clk = 1'b0;
  logic rst_n;

  i2c_init_if bus ();

  i2c_init #(
    .STARTUP_CYCLES(64),
    .DEV_ADDR      (7'h10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  logic [1:0] exp_wave[$];
  logic [7:0] golden[11] = '{8'h20, 8'h01, 8'h0C, 8'h1C, 8'h00, 8'h22,
                             8'h22, 8'h00, 8'h20, 8'h00, 8'h37};

  // Decoder state
  logic [7:0] dec_log[$];
  int         trans_lens[$];
  int         start_cnt;
  logic       m_pscl, m_psda, m_in_frame, m_track, m_pend;
  int         m_hlen, m_nbits, m_len;
  logic [7:0] m_cur;

  // Shared comparison: counts every check and reports each failure.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drives rst_n just after a rising edge, then lets n edges pass. When
  // reset is asserted the pads must be released before the next edge.
  task automatic applyStimulus(input logic rst_val, input int n);
    @(posedge clk);
    #2;
    rst_n = rst_val;
    if (!rst_val) begin
      #1;
      checkOutput("async_release", {bus.scl, bus.sda_out}, 2'b11);
    end
    repeat (n) @(posedge clk);
  endtask

  // Expected {scl,sda} indexed by rising edges since reset release.
  task automatic pushBit(input logic v);
    exp_wave.push_back({1'b0, v});
    exp_wave.push_back({1'b1, v});
    exp_wave.push_back({1'b1, v});
    exp_wave.push_back({1'b0, v});
  endtask

  task automatic buildModel();
    int first, nbytes;
    logic [7:0] b;
    exp_wave.delete();
    exp_wave.push_back(2'b11);
    repeat (64) exp_wave.push_back(2'b11);
    for (int t = 0; t < 2; t++) begin
      if (t == 1) repeat (4) exp_wave.push_back(2'b11);
      first  = (t == 0) ? 0 : 8;
      nbytes = (t == 0) ? 8 : 3;
      exp_wave.push_back(2'b11);
      exp_wave.push_back(2'b10);
      exp_wave.push_back(2'b10);
      exp_wave.push_back(2'b00);
      for (int k = 0; k < nbytes; k++) begin
        b = golden[first + k];
        for (int i = 0; i < 8; i++) pushBit(b[7 - i]);
        pushBit(1'b1);
      end
      exp_wave.push_back(2'b00);
      exp_wave.push_back(2'b10);
      exp_wave.push_back(2'b10);
      exp_wave.push_back(2'b11);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Per-cycle comparison against the waveform model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n)
        checkOutput("reset_hold", {bus.scl, bus.sda_out}, 2'b11);
      else if (cyc < exp_wave.size())
        checkOutput($sformatf("wave_cyc%0d", cyc), {bus.scl, bus.sda_out}, exp_wave[cyc]);
      else
        checkOutput("done_idle", {bus.scl, bus.sda_out}, 2'b11);
    end
  end

  // Bus decoder: frames on START/STOP, latches SDA on SCL rise and commits
  // the bit on SCL fall (so the STOP's SCL rise is not taken as data).
  always @(negedge clk) begin
    if (!rst_n) begin
      dec_log.delete();
      trans_lens.delete();
      start_cnt  = 0;
      m_pscl     = 1'b1;
      m_psda     = 1'b1;
      m_in_frame = 1'b0;
      m_track    = 1'b0;
      m_hlen     = 0;
      m_nbits    = 0;
      m_len      = 0;
      m_cur      = 8'h00;
      m_pend     = 1'b0;
    end else begin
      if (m_pscl && bus.scl && m_psda && !bus.sda_out) begin
        start_cnt++;
        m_in_frame = 1'b1;
        m_track    = 1'b0;
        m_nbits    = 0;
        m_len      = 0;
      end else if (m_pscl && bus.scl && !m_psda && bus.sda_out) begin
        if (m_in_frame) trans_lens.push_back(m_len);
        m_in_frame = 1'b0;
        m_track    = 1'b0;
      end else if (!m_pscl && bus.scl && m_in_frame) begin
        m_pend  = bus.sda_out;
        m_track = 1'b1;
        m_hlen  = 1;
      end else if (m_pscl && bus.scl && m_track) begin
        m_hlen++;
      end else if (m_pscl && !bus.scl && m_track) begin
        m_track = 1'b0;
        if (chk_en) checkOutput("scl_high_len", m_hlen, 2);
        if ((m_nbits % 9) < 8) begin
          m_cur = {m_cur[6:0], m_pend};
          if ((m_nbits % 9) == 7) begin
            dec_log.push_back(m_cur);
            m_len++;
          end
        end else if (chk_en) begin
          checkOutput("ack_slot", m_pend, 1'b1);
        end
        m_nbits++;
      end
      m_pscl = bus.scl;
      m_psda = bus.sda_out;
    end
  end

  task automatic checkDecode();
    checkOutput("trans_count", trans_lens.size(), 2);
    checkOutput("start_count", start_cnt, 2);
    if (trans_lens.size() >= 1) checkOutput("t1_len", trans_lens[0], 8);
    if (trans_lens.size() >= 2) checkOutput("t2_len", trans_lens[1], 3);
    checkOutput("byte_count", dec_log.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < dec_log.size())
        checkOutput($sformatf("byte%0d", i), dec_log[i], golden[i]);
    end
  endtask

  // Release reset, locate the START's SDA fall, then run well past DONE.
  task automatic runFull();
    bit found;
    found = 1'b0;
    applyStimulus(1'b1, 0);
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      #1;
      if (bus.sda_out === 1'b0) begin
        found = 1'b1;
        checkOutput("start_fall_cycle", cyc, 66);
        checkOutput("start_fall_scl", bus.scl, 1'b1);
      end
    end
    if (!found) checkOutput("start_fall_timeout", 0, 1);
    while (cyc < 1480) @(posedge clk);
    #1;
    checkDecode();
  endtask

  initial begin
    rst_n = 1'b0;
    buildModel();

    // Hand-derived points of the default waveform.
    checkOutput("model_len",      exp_wave.size(), 481);
    checkOutput("model_wait_end", exp_wave[64],  2'b11);
    checkOutput("model_start_p0", exp_wave[65],  2'b11);
    checkOutput("model_start_p1", exp_wave[66],  2'b10);
    checkOutput("model_start_p3", exp_wave[68],  2'b00);
    checkOutput("model_b0_p0",    exp_wave[69],  2'b00);
    checkOutput("model_b0_p1",    exp_wave[70],  2'b10);
    checkOutput("model_b0_bit2",  exp_wave[78],  2'b11);
    checkOutput("model_b0_ack",   exp_wave[102], 2'b11);
    checkOutput("model_stop1_p0", exp_wave[357], 2'b00);
    checkOutput("model_stop1_p3", exp_wave[360], 2'b11);
    checkOutput("model_start2",   exp_wave[366], 2'b10);
    checkOutput("model_end",      exp_wave[480], 2'b11);

    chk_en = 1'b1;
    applyStimulus(1'b0, 10);

    // Random abort inside the first transaction, random short reset.
    applyStimulus(1'b1, $urandom_range(80, 340));
    applyStimulus(1'b0, $urandom_range(2, 10));

    // Random abort anywhere in the sequence, 10-cycle reset hold.
    applyStimulus(1'b1, $urandom_range(66, 470));
    applyStimulus(1'b0, 10);

    runFull();

    // Mid-run reset at cycle 200, then a complete rerun.
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 199);
    applyStimulus(1'b0, 10);
    runFull();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
